// File: rtl/mca_pkg.sv
// Shared types and constants for the multichannel-analyser histogram.
package mca_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam int ADDR_W_DEF = 10;
   localparam int CNT_W_DEF  = 32;
   localparam int DROP_W_DEF = 16;

   localparam logic [CNT_W_DEF-1:0] MAX_COUNT = '1;

endpackage

// File: rtl/mca_dpram.sv
// Spectrum RAM: one write port, RMW read port A, readout port B.
// Reads are registered and return old data on a same-address write.
module mca_dpram
   import mca_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [CNT_W-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [CNT_W-1:0]  rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [CNT_W-1:0]  rd_data_b
);

   logic [CNT_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
   end

endmodule

// File: rtl/mca_histogram.sv
// Histogram spectrum memory: FSM, clear sweep, forwarded RMW
// increment pipeline and dropped-event counter.
module mca_histogram
   import mca_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int DROP_W = DROP_W_DEF
) (
   input  logic              CLOCK_50,
   input  logic              rst_n,
   input  logic              cmd_start,
   input  logic              cmd_pause,
   input  logic              cmd_clear,
   input  logic              evt_valid,
   input  logic [ADDR_W-1:0] evt_channel,
   output logic              evt_ready,
   input  logic [ADDR_W-1:0] channel_address,
   output logic [CNT_W-1:0]  channel_count,
   output logic              running,
   output logic              clearing,
   output logic [DROP_W-1:0] drop_count
);

   localparam logic [ADDR_W-1:0] SWEEP_LAST = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE   = 1;
   localparam logic [DROP_W-1:0] DROP_MAX   = '1;
   localparam logic [DROP_W-1:0] DROP_ONE   = 1;
   localparam logic [CNT_W:0]    INC_ONE    = 1;

   state_t            state;
   logic [ADDR_W-1:0] sweep;
   logic              wr_vld;
   logic [ADDR_W-1:0] wr_addr;
   logic              fwd;
   logic [CNT_W-1:0]  fwd_data;
   logic [CNT_W-1:0]  rd_a;
   logic [CNT_W-1:0]  rd_b;
   logic [CNT_W-1:0]  old_val;
   logic [CNT_W:0]    sum;
   logic [CNT_W-1:0]  inc_val;
   logic              acc;
   logic              clr_go;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_wa;
   logic [CNT_W-1:0]  ram_wd;

   assign evt_ready = (state == ST_RUN);
   assign acc       = evt_valid & evt_ready;
   assign clr_go    = cmd_clear & (state != ST_CLEAR);

   // Back-to-back hits on one bin see the value written last cycle.
   assign old_val = fwd ? fwd_data : rd_a;
   assign sum     = {1'b0, old_val} + INC_ONE;
   assign inc_val = sum[CNT_W] ? old_val : sum[CNT_W-1:0];

   // An in-flight increment owns the write port; the sweep stalls.
   assign ram_we = wr_vld | (state == ST_CLEAR);
   assign ram_wa = wr_vld ? wr_addr : sweep;
   assign ram_wd = wr_vld ? inc_val : '0;

   mca_dpram #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_ram (
      .clk       (CLOCK_50),
      .we        (ram_we),
      .wr_addr   (ram_wa),
      .wr_data   (ram_wd),
      .rd_addr_a (evt_channel),
      .rd_data_a (rd_a),
      .rd_addr_b (channel_address),
      .rd_data_b (rd_b)
   );

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         wr_vld   <= 1'b0;
         wr_addr  <= '0;
         fwd      <= 1'b0;
         fwd_data <= '0;
      end else begin
         wr_vld   <= acc;
         wr_addr  <= evt_channel;
         fwd      <= acc & wr_vld & (evt_channel == wr_addr);
         fwd_data <= inc_val;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_CLEAR;
         sweep    <= '0;
         running  <= 1'b0;
         clearing <= 1'b1;
      end else begin
         unique case (state)
            ST_CLEAR: begin
               if (!wr_vld) begin
                  sweep <= sweep + ADDR_ONE;
                  if (sweep == SWEEP_LAST) begin
                     state    <= ST_IDLE;
                     clearing <= 1'b0;
                  end
               end
            end
            ST_IDLE: begin
               if (cmd_clear) begin
                  state    <= ST_CLEAR;
                  sweep    <= '0;
                  clearing <= 1'b1;
               end else if (cmd_start) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (cmd_clear) begin
                  state    <= ST_CLEAR;
                  sweep    <= '0;
                  running  <= 1'b0;
                  clearing <= 1'b1;
               end else if (cmd_pause) begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
               end
            end
            default: begin
               state    <= ST_CLEAR;
               sweep    <= '0;
               running  <= 1'b0;
               clearing <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n)
         drop_count <= '0;
      else if (clr_go)
         drop_count <= '0;
      else if (evt_valid & ~evt_ready & (drop_count != DROP_MAX))
         drop_count <= drop_count + DROP_ONE;
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n)
         channel_count <= '0;
      else
         channel_count <= rd_b;
   end

endmodule

// File: tb/tb_mca_histogram.sv
// Directed bench for mca_histogram with a readout scoreboard.
module tb_mca_histogram;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        cmd_start = 0, cmd_pause = 0, cmd_clear = 0;
   logic        evt_valid = 0;
   logic [9:0]  evt_channel = '0;
   logic [9:0]  channel_address = '0;
   logic        evt_ready, running, clearing;
   logic [31:0] channel_count;
   logic [15:0] drop_count;

   logic        s_start = 0, s_pause = 0, s_clear = 0;
   logic        s_valid = 0;
   logic [9:0]  s_channel = '0;
   logic [9:0]  s_address = '0;
   logic        s_ready, s_running, s_clearing;
   logic [3:0]  s_count;
   logic [15:0] s_drop;

   int errors = 0;
   int checks = 0;

   always #10 clk = ~clk;

   mca_histogram #(.ADDR_W(10), .CNT_W(32), .DROP_W(16)) dut (
      .CLOCK_50        (clk),
      .rst_n           (rst_n),
      .cmd_start       (cmd_start),
      .cmd_pause       (cmd_pause),
      .cmd_clear       (cmd_clear),
      .evt_valid       (evt_valid),
      .evt_channel     (evt_channel),
      .evt_ready       (evt_ready),
      .channel_address (channel_address),
      .channel_count   (channel_count),
      .running         (running),
      .clearing        (clearing),
      .drop_count      (drop_count)
   );

   mca_histogram #(.ADDR_W(10), .CNT_W(4), .DROP_W(16)) dut_sat (
      .CLOCK_50        (clk),
      .rst_n           (rst_n),
      .cmd_start       (s_start),
      .cmd_pause       (s_pause),
      .cmd_clear       (s_clear),
      .evt_valid       (s_valid),
      .evt_channel     (s_channel),
      .evt_ready       (s_ready),
      .channel_address (s_address),
      .channel_count   (s_count),
      .running         (s_running),
      .clearing        (s_clearing),
      .drop_count      (s_drop)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Readout scoreboard: expectation queued when the address is driven.
   logic        rd_req = 1'b0;
   logic        p1 = 1'b0, p2 = 1'b0;
   logic [31:0] exp_q[$];
   bit          sel_q[$];
   string       tag_q[$];

   always @(posedge clk) begin
      p1 <= rd_req;
      p2 <= p1;
   end

   always @(negedge clk) begin
      if (p2) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            automatic logic [31:0] e = exp_q.pop_front();
            automatic bit          s = sel_q.pop_front();
            automatic string       t = tag_q.pop_front();
            chk(t, s ? {28'd0, s_count} : channel_count, e);
         end
      end
   end

   task automatic rd(input bit sel, input int a, input logic [31:0] e,
                     input string tag);
      @(negedge clk);
      if (sel) s_address = 10'(a);
      else     channel_address = 10'(a);
      rd_req = 1'b1;
      exp_q.push_back(e);
      sel_q.push_back(sel);
      tag_q.push_back(tag);
   endtask

   task automatic rd_flush();
      @(negedge clk);
      rd_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic cmd(input bit sel, input bit st, input bit pa,
                      input bit cl);
      @(negedge clk);
      if (sel) begin s_start = st; s_pause = pa; s_clear = cl; end
      else begin cmd_start = st; cmd_pause = pa; cmd_clear = cl; end
      @(negedge clk);
      cmd_start = 0; cmd_pause = 0; cmd_clear = 0;
      s_start = 0; s_pause = 0; s_clear = 0;
   endtask

   task automatic evt(input bit sel, input int ch);
      @(negedge clk);
      if (sel) begin s_valid = 1; s_channel = 10'(ch); end
      else begin evt_valid = 1; evt_channel = 10'(ch); end
   endtask

   task automatic evt_off();
      @(negedge clk);
      evt_valid = 0;
      s_valid = 0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (clearing && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(clearing), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seq[7] = '{3, 4, 3, 4, 3, 3, 3};

      repeat (3) @(negedge clk);
      chk("rst_clearing", 32'(clearing), 32'd1);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_ready", 32'(evt_ready), 32'd0);
      chk("rst_count", channel_count, 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);

      rst_n = 1'b1;
      n = 0;
      while (clearing && n < 2000) begin
         n++;
         @(negedge clk);
      end
      chk("clr_len", 32'(n), 32'd1024);
      chk("clr_idle_run", 32'(running), 32'd0);
      chk("sat_clr_done", 32'(s_clearing), 32'd0);
      rd(0, 0, 0, "rd0_init");
      rd(0, 511, 0, "rd511_init");
      rd(0, 1023, 0, "rd1023_init");
      rd_flush();

      cmd(0, 1, 0, 0);
      chk("run_running", 32'(running), 32'd1);
      chk("run_ready", 32'(evt_ready), 32'd1);
      repeat (5) evt(0, 7);
      evt_off();
      cmd(0, 0, 1, 0);
      chk("pause_running", 32'(running), 32'd0);
      chk("pause_ready", 32'(evt_ready), 32'd0);
      rd(0, 7, 5, "bin7");
      rd(0, 6, 0, "bin6");
      rd(0, 8, 0, "bin8");
      rd(0, 0, 0, "bin0");
      rd_flush();
      chk("drop_after_run", 32'(drop_count), 32'd0);

      cmd(0, 1, 0, 0);
      foreach (seq[i]) evt(0, seq[i]);
      evt_off();
      cmd(0, 0, 1, 0);
      rd(0, 3, 5, "bin3_fwd");
      rd(0, 4, 2, "bin4_alt");
      rd(0, 7, 5, "bin7_keep");
      rd_flush();

      cmd(1, 1, 0, 0);
      repeat (20) evt(1, 1);
      evt_off();
      cmd(1, 0, 1, 0);
      rd(1, 1, 15, "sat_bin1");
      rd(1, 0, 0, "sat_bin0");
      rd_flush();
      cmd(1, 1, 0, 0);
      repeat (3) evt(1, 1);
      evt_off();
      cmd(1, 0, 1, 0);
      rd(1, 1, 15, "sat_bin1_stay");
      rd_flush();

      repeat (6) evt(0, 5);
      evt_off();
      chk("idle_drop6", 32'(drop_count), 32'd6);
      rd(0, 5, 0, "bin5_idle");
      rd(0, 7, 5, "bin7_idle");
      rd_flush();
      cmd(0, 0, 0, 1);
      chk("clr_drop0", 32'(drop_count), 32'd0);
      chk("clr_flag", 32'(clearing), 32'd1);
      wait_idle("clr_sweep_done");
      rd(0, 7, 0, "bin7_clr");
      rd(0, 3, 0, "bin3_clr");
      rd(0, 4, 0, "bin4_clr");
      rd(0, 1023, 0, "bin1023_clr");
      rd_flush();

      cmd(0, 1, 0, 0);
      @(negedge clk);
      cmd_start = 1; cmd_clear = 1;
      evt_valid = 1; evt_channel = 10'd9;
      @(negedge clk);
      cmd_start = 0; cmd_clear = 0; evt_valid = 0;
      chk("sc_clearing", 32'(clearing), 32'd1);
      chk("sc_running", 32'(running), 32'd0);
      chk("sc_ready", 32'(evt_ready), 32'd0);
      wait_idle("sc_sweep_done");
      chk("sc_end_idle", 32'(running), 32'd0);
      rd(0, 9, 0, "bin9_sc");
      rd_flush();
      chk("sc_drop", 32'(drop_count), 32'd0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
